// File: rtl/instruction_prefetch_buffer.sv
// instruction_prefetch_buffer
//
// Purpose: fetches word-aligned 32-bit instruction words ahead of the core's
// PC into a small FIFO. It answers core lookups combinationally from the two
// oldest FIFO entries. When the core's address leaves the prefetched stream,
// it resynchronises to that address. Memory data that arrives for an
// abandoned request is dropped.
//
// Parameters:
//   DEPTH         FIFO entries (power of two, >= 2)
//   BOOT_ADDRESS  first word fetched after reset
//
// Ports:
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset
//   flush_i                 drop FIFO contents and any in-flight fetch
//   instruction_request_i   core lookup valid
//   instruction_addr_i      core PC (bits [1:0] ignored)
//   instruction_response_o  instruction_data_o holds the word at the PC
//   instruction_data_o      matched instruction word
//   mem_req_o               registered memory read request
//   mem_addr_o              registered word address of the request
//   mem_ack_i               memory read done, mem_data_i valid
//   mem_data_i              memory read data

module instruction_prefetch_buffer #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] BOOT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        instruction_request_i,
  input  logic [31:0] instruction_addr_i,
  output logic        instruction_response_o,
  output logic [31:0] instruction_data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_next_entry;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   next_addr;
  logic [1:0]    state;

  logic [31:0] word_addr;
  logic        match0;
  logic        match1;
  logic        lookup;
  logic        pop;
  logic        miss;
  logic        redirect;
  logic        clear;
  logic        ack;
  logic        push;
  logic        unused_addr_bits;

  // The low PC bits never select a different word, so they are discarded.
  assign unused_addr_bits = ^instruction_addr_i[1:0];
  assign word_addr        = {instruction_addr_i[31:2], 2'b00};

  assign rd_ptr_next_entry = rd_ptr + PW'(1);
  assign match0 = (count >= CW'(1)) && (addr_q[rd_ptr] == word_addr);
  assign match1 = (count >= CW'(2)) && (addr_q[rd_ptr_next_entry] == word_addr);

  assign instruction_response_o = instruction_request_i & (match0 | match1);
  assign instruction_data_o     = match0 ? data_q[rd_ptr] :
                                  match1 ? data_q[rd_ptr_next_entry] : 32'h0;

  // Lookup actions are suppressed while a flush is in progress. A miss on the
  // address we are about to fetch just waits. Any other miss is a redirect.
  assign lookup   = instruction_request_i & ~flush_i;
  assign pop      = lookup & ~match0 & match1;
  assign miss     = lookup & ~match0 & ~match1;
  assign redirect = miss & (word_addr != next_addr);
  assign clear    = flush_i | miss;

  // Acks only count while a request is outstanding. Data is pushed only for
  // a live (non-dropped, non-redirected) request.
  assign ack  = mem_ack_i & mem_req_o;
  assign push = (state == BUSY) & ack & ~flush_i & ~redirect;

  // Occupancy after this edge. A clear empties the FIFO, but a word pushed
  // in the same cycle survives as the only entry.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = push ? CW'(1) : CW'(0);
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // FIFO storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= mem_addr_o;
      data_q[wr_ptr] <= mem_data_i;
    end
  end

  // Pointers, occupancy, the fetch address and the fetch FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req_o <= 1'b0;
      mem_addr_o <= BOOT_ADDRESS;
      next_addr <= BOOT_ADDRESS;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      count <= count_next;

      // Clearing moves the read pointer onto the write pointer. A word
      // pushed this same edge lands there and becomes the new head.
      if (clear) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr_next_entry;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      if (redirect) begin
        next_addr <= word_addr;
      end else if (push) begin
        next_addr <= next_addr + 32'd4;
      end

      case (state)
        IDLE: begin
          if ((count < CW'(DEPTH)) && !redirect && !flush_i) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= next_addr;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (ack) begin
            if (flush_i || redirect || (count_next >= CW'(DEPTH))) begin
              mem_req_o <= 1'b0;
              state     <= IDLE;
            end else begin
              mem_addr_o <= mem_addr_o + 32'd4;
            end
          end else if (flush_i || redirect) begin
            // The memory still owes us this word; wait for it, then discard.
            state <= DROP;
          end
        end
        DROP: begin
          if (ack) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// tb_instruction_prefetch_buffer
//
// Purpose: directed bench for instruction_prefetch_buffer with DEPTH=4 and
// BOOT_ADDRESS=0x100. A small memory responder answers after a programmable
// number of wait cycles. Each word's data is derived from its address.

module tb_instruction_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        instruction_request_i;
  logic [31:0] instruction_addr_i;
  logic        instruction_response_o;
  logic [31:0] instruction_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int          waitStates;
  logic [7:0]  waitCnt;
  int          checkCount;
  int          failCount;

  instruction_prefetch_buffer #(
    .DEPTH        (4),
    .BOOT_ADDRESS (32'h00000100)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush_i                (flush_i),
    .instruction_request_i  (instruction_request_i),
    .instruction_addr_i     (instruction_addr_i),
    .instruction_response_o (instruction_response_o),
    .instruction_data_o     (instruction_data_o),
    .mem_req_o              (mem_req_o),
    .mem_addr_o             (mem_addr_o),
    .mem_ack_i              (mem_ack_i),
    .mem_data_i             (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at a given address in the model memory.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory responder: acks once the request has waited waitStates cycles.
  assign mem_ack_i  = mem_req_o && (int'(waitCnt) >= waitStates);
  assign mem_data_i = mem_req_o ? memWord(mem_addr_o) : 32'h0;

  always @(posedge clk) begin
    if (rst || !mem_req_o || mem_ack_i) begin
      waitCnt <= 8'd0;
    end else begin
      waitCnt <= waitCnt + 8'd1;
    end
  end

  // Move to the next cycle, just after the active edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the core-side inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic flush);
    instruction_request_i = req;
    instruction_addr_i    = addr;
    flush_i               = flush;
    #2;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    waitStates = 0;
    rst        = 1'b1;
    instruction_request_i = 1'b0;
    instruction_addr_i    = 32'h0;
    flush_i               = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("reset_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("reset_addr", mem_addr_o, 32'h100);
    checkOutput("reset_resp", {31'b0, instruction_response_o}, 32'd0);

    // Release reset; the first request goes out the cycle after.
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("c0_req", {31'b0, mem_req_o}, 32'd0);

    nextCycle();
    checkOutput("c1_req", {31'b0, mem_req_o}, 32'd1);
    checkOutput("c1_addr", mem_addr_o, 32'h100);
    checkOutput("c1_resp", {31'b0, instruction_response_o}, 32'd0);

    nextCycle();
    checkOutput("c2_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("c2_data", instruction_data_o, memWord(32'h100));
    checkOutput("c2_addr", mem_addr_o, 32'h104);

    nextCycle();
    checkOutput("c3_addr", mem_addr_o, 32'h108);
    nextCycle();
    checkOutput("c4_req", {31'b0, mem_req_o}, 32'd1);
    checkOutput("c4_addr", mem_addr_o, 32'h10C);
    nextCycle();
    checkOutput("full_req", {31'b0, mem_req_o}, 32'd0);

    // Stalled PC on a hit: no pop, same data, FIFO stays full.
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput("stall_resp", {31'b0, instruction_response_o}, 32'd1);
      checkOutput("stall_data", instruction_data_o, memWord(32'h100));
      checkOutput("stall_req", {31'b0, mem_req_o}, 32'd0);
    end
    checkOutput("stall_count", 32'(dut.count), 32'd4);

    // Jump to 0x200 from a full FIFO.
    nextCycle();
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("jump_resp", {31'b0, instruction_response_o}, 32'd0);
    nextCycle();
    checkOutput("jump1_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("jump1_resp", {31'b0, instruction_response_o}, 32'd0);
    nextCycle();
    checkOutput("jump2_req", {31'b0, mem_req_o}, 32'd1);
    checkOutput("jump2_addr", mem_addr_o, 32'h200);
    nextCycle();
    checkOutput("jump3_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("jump3_data", instruction_data_o, memWord(32'h200));
    checkOutput("jump3_addr", mem_addr_o, 32'h204);

    // Compressed and unaligned steps hit every cycle.
    nextCycle();
    applyStimulus(1'b1, 32'h202, 1'b0);
    checkOutput("step202_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("step202_data", instruction_data_o, memWord(32'h200));
    nextCycle();
    applyStimulus(1'b1, 32'h204, 1'b0);
    checkOutput("step204_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("step204_data", instruction_data_o, memWord(32'h204));
    nextCycle();
    applyStimulus(1'b1, 32'h206, 1'b0);
    checkOutput("step206_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("step206_data", instruction_data_o, memWord(32'h204));
    checkOutput("step206_addr", mem_addr_o, 32'h210);
    nextCycle();
    applyStimulus(1'b1, 32'h208, 1'b0);
    checkOutput("step208_data", instruction_data_o, memWord(32'h208));
    checkOutput("step208_req", {31'b0, mem_req_o}, 32'd0);

    // Refill request to 0x214 waits three cycles; jump to 0x300 mid-wait.
    nextCycle();
    waitStates = 3;
    checkOutput("pop_head_data", instruction_data_o, memWord(32'h208));
    nextCycle();
    checkOutput("slow_req", {31'b0, mem_req_o}, 32'd1);
    checkOutput("slow_addr", mem_addr_o, 32'h214);
    nextCycle();
    applyStimulus(1'b1, 32'h300, 1'b0);
    checkOutput("drop_jump_resp", {31'b0, instruction_response_o}, 32'd0);
    nextCycle();
    checkOutput("drop_hold_addr", mem_addr_o, 32'h214);
    checkOutput("drop_hold_resp", {31'b0, instruction_response_o}, 32'd0);
    nextCycle();
    checkOutput("drop_ack_seen", {31'b0, mem_ack_i}, 32'd1);
    checkOutput("drop_ack_resp", {31'b0, instruction_response_o}, 32'd0);
    checkOutput("drop_ack_data", instruction_data_o, 32'h0);
    nextCycle();
    waitStates = 0;
    checkOutput("drop_idle_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("drop_idle_resp", {31'b0, instruction_response_o}, 32'd0);
    nextCycle();
    checkOutput("redir_req", {31'b0, mem_req_o}, 32'd1);
    checkOutput("redir_addr", mem_addr_o, 32'h300);
    nextCycle();
    checkOutput("redir_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("redir_data", instruction_data_o, memWord(32'h300));
    checkOutput("redir_next_addr", mem_addr_o, 32'h304);

    // Flush coinciding with an ack: the word is discarded, FIFO empties.
    nextCycle();
    applyStimulus(1'b0, 32'h300, 1'b1);
    checkOutput("flush_ack_seen", {31'b0, mem_ack_i}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h300, 1'b0);
    checkOutput("flush_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("flush_resp", {31'b0, instruction_response_o}, 32'd0);
    checkOutput("flush_count", 32'(dut.count), 32'd0);
    nextCycle();
    checkOutput("resync_idle_req", {31'b0, mem_req_o}, 32'd0);
    nextCycle();
    checkOutput("resync_req", {31'b0, mem_req_o}, 32'd1);
    checkOutput("resync_addr", mem_addr_o, 32'h300);
    nextCycle();
    checkOutput("resync_resp", {31'b0, instruction_response_o}, 32'd1);
    checkOutput("resync_data", instruction_data_o, memWord(32'h300));

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
